// File: rtl/display_timing.sv
// display_timing: VGA-style raster timing generator with frame-latched scroll offsets.
// Optional macro DISPLAY_TIMING_FRAME_COUNT_EN builds the 16-bit frame_count counter.
module display_timing #(
    parameter int COORD_WIDTH = 10,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [COORD_WIDTH-1:0] x_offset,
    input  logic [COORD_WIDTH-1:0] y_offset,
    output logic [COORD_WIDTH-1:0] x_pos,
    output logic [COORD_WIDTH-1:0] y_pos,
    output logic [COORD_WIDTH-1:0] scroll_x,
    output logic [COORD_WIDTH-1:0] scroll_y,
    output logic                   hsync_n,
    output logic                   vsync_n,
    output logic                   blank,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [15:0]            frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_WIDTH-1:0] COORD_ZERO = {COORD_WIDTH{1'b0}};
    localparam logic [COORD_WIDTH-1:0] COORD_ONE  = {{(COORD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COORD_WIDTH-1:0] H_LAST     = COORD_WIDTH'(H_TOTAL - 1);
    localparam logic [COORD_WIDTH-1:0] V_LAST     = COORD_WIDTH'(V_TOTAL - 1);
    localparam logic [COORD_WIDTH-1:0] H_VIS_END  = COORD_WIDTH'(H_VISIBLE);
    localparam logic [COORD_WIDTH-1:0] V_VIS_END  = COORD_WIDTH'(V_VISIBLE);
    localparam logic [COORD_WIDTH-1:0] HS_BEGIN   = COORD_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_WIDTH-1:0] HS_END     = COORD_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_WIDTH-1:0] VS_BEGIN   = COORD_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_WIDTH-1:0] VS_END     = COORD_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]             state_r;
    logic [0:0]             state_s;
    logic [COORD_WIDTH-1:0] x_r;
    logic [COORD_WIDTH-1:0] y_r;
    logic [COORD_WIDTH-1:0] x_s;
    logic [COORD_WIDTH-1:0] y_s;
    logic [COORD_WIDTH-1:0] x_off_r;
    logic [COORD_WIDTH-1:0] y_off_r;
    logic                   load_off_s;
    logic                   frame_edge_s;
    logic                   active_s;
    logic                   hsync_n_s;
    logic                   vsync_n_s;
    logic                   blank_s;
    logic                   line_start_s;
    logic                   hsync_n_r;
    logic                   vsync_n_r;
    logic                   blank_r;
    logic                   line_start_r;
    logic                   frame_start_r;

    // Next-state counters: idle parks at origin, first enabled edge starts a frame at (0,0)
    always_comb begin
        state_s      = state_r;
        x_s          = COORD_ZERO;
        y_s          = COORD_ZERO;
        load_off_s   = 1'b0;
        frame_edge_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s      = ST_RUN;
                    load_off_s   = 1'b1;
                    frame_edge_s = 1'b1;
                end else begin
                    state_s      = ST_IDLE;
                    load_off_s   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_s    = ST_IDLE;
                    load_off_s = 1'b1;
                end else if (x_r == H_LAST) begin
                    state_s = ST_RUN;
                    x_s     = COORD_ZERO;
                    if (y_r == V_LAST) begin
                        y_s          = COORD_ZERO;
                        load_off_s   = 1'b1;
                        frame_edge_s = 1'b1;
                    end else begin
                        y_s = y_r + COORD_ONE;
                    end
                end else begin
                    state_s = ST_RUN;
                    x_s     = x_r + COORD_ONE;
                    y_s     = y_r;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                load_off_s = 1'b1;
            end
        endcase
    end

    // Strobes derived from next-state counters so they land in the same cycle as x_pos/y_pos
    always_comb begin
        active_s = (state_s == ST_RUN);
        if (active_s) begin
            hsync_n_s    = !((x_s >= HS_BEGIN) && (x_s < HS_END));
            vsync_n_s    = !((y_s >= VS_BEGIN) && (y_s < VS_END));
            blank_s      = (x_s >= H_VIS_END) || (y_s >= V_VIS_END);
            line_start_s = (x_s == COORD_ZERO);
        end else begin
            hsync_n_s    = 1'b1;
            vsync_n_s    = 1'b1;
            blank_s      = 1'b1;
            line_start_s = 1'b0;
        end
    end

    // Counter, strobe and offset-latch registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            x_r           <= COORD_ZERO;
            y_r           <= COORD_ZERO;
            x_off_r       <= COORD_ZERO;
            y_off_r       <= COORD_ZERO;
            hsync_n_r     <= 1'b1;
            vsync_n_r     <= 1'b1;
            blank_r       <= 1'b1;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            x_r           <= x_s;
            y_r           <= y_s;
            hsync_n_r     <= hsync_n_s;
            vsync_n_r     <= vsync_n_s;
            blank_r       <= blank_s;
            line_start_r  <= line_start_s;
            frame_start_r <= frame_edge_s;
            if (load_off_s) begin
                x_off_r <= x_offset;
                y_off_r <= y_offset;
            end else begin
                x_off_r <= x_off_r;
                y_off_r <= y_off_r;
            end
        end
    end

    assign x_pos       = x_r;
    assign y_pos       = y_r;
    assign scroll_x    = x_r + x_off_r;
    assign scroll_y    = y_r + y_off_r;
    assign hsync_n     = hsync_n_r;
    assign vsync_n     = vsync_n_r;
    assign blank       = blank_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
    logic [15:0] frame_count_r;

    // Frames started since reset; wraps at 2^16
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count_r <= 16'h0000;
        end else if (frame_edge_s) begin
            frame_count_r <= frame_count_r + 16'h0001;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign frame_count = frame_count_r;
`else
    assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_display_timing.sv
// Scoreboard bench for display_timing on a shrunken raster (30x19) so whole frames fit a short run.
module tb_display_timing;

    localparam int CW = 10;
    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 30
    localparam int VT = VV + VF + VS + VB;   // 19

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] x_offset = '0;
    logic [CW-1:0] y_offset = '0;
    logic [CW-1:0] x_pos, y_pos, scroll_x, scroll_y;
    logic          hsync_n, vsync_n, blank, line_start, frame_start;
    logic [15:0]   frame_count;

    display_timing #(
        .COORD_WIDTH(CW), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .x_offset(x_offset), .y_offset(y_offset),
        .x_pos(x_pos), .y_pos(y_pos), .scroll_x(scroll_x), .scroll_y(scroll_y),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .blank(blank),
        .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] x, y, sx, sy;
        logic          hs, vs, bl, ls, fs;
        logic [15:0]   fc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference raster state
    int mx = 0, my = 0, mxl = 0, myl = 0, mfc = 0;
    bit m_act = 1'b0;

    function automatic exp_t expect_now();
        exp_t e;
        e.x  = CW'(mx);
        e.y  = CW'(my);
        e.sx = CW'((mx + mxl) % 1024);
        e.sy = CW'((my + myl) % 1024);
        if (m_act) begin
            e.hs = !(mx >= HV + HF && mx < HV + HF + HS);
            e.vs = !(my >= VV + VF && my < VV + VF + VS);
            e.bl = (mx >= HV) || (my >= VV);
            e.ls = (mx == 0);
            e.fs = (mx == 0) && (my == 0);
        end else begin
            e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b1; e.ls = 1'b0; e.fs = 1'b0;
        end
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
        e.fc = 16'(mfc);
`else
        e.fc = 16'h0000;
`endif
        return e;
    endfunction

    // Advance the model by one edge using the inputs now driven, queue the expectation, wait one cycle
    task automatic tick();
        if (!reset) begin
            mx = 0; my = 0; m_act = 1'b0; mxl = 0; myl = 0; mfc = 0;
        end else if (!enable) begin
            mx = 0; my = 0; m_act = 1'b0; mxl = int'(x_offset); myl = int'(y_offset);
        end else if (!m_act) begin
            mx = 0; my = 0; m_act = 1'b1; mxl = int'(x_offset); myl = int'(y_offset);
            mfc = (mfc + 1) % 65536;
        end else begin
            mx = mx + 1;
            if (mx == HT) begin
                mx = 0;
                my = (my + 1 == VT) ? 0 : my + 1;
                if (my == 0) begin
                    mxl = int'(x_offset); myl = int'(y_offset);
                    mfc = (mfc + 1) % 65536;
                end
            end
        end
        q.push_back(expect_now());
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a raster state; compare against the queued expectation
    always @(negedge clk) begin
        exp_t e, g;
        if (q.size() > 0) begin
            e = q.pop_front();
            g.x = x_pos; g.y = y_pos; g.sx = scroll_x; g.sy = scroll_y;
            g.hs = hsync_n; g.vs = vsync_n; g.bl = blank; g.ls = line_start; g.fs = frame_start;
            g.fc = frame_count;
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL raster t=%0t got x=%0d y=%0d sx=%0d sy=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d sx=%0d sy=%0d hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d",
                         $time, g.x, g.y, g.sx, g.sy, g.hs, g.vs, g.bl, g.ls, g.fs, g.fc,
                         e.x, e.y, e.sx, e.sy, e.hs, e.vs, e.bl, e.ls, e.fs, e.fc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ls, n_fs, n_hs, n_vs, n_bl;
        reset = 1'b0; enable = 1'b1;
        @(negedge clk); #1;
        check("rst_x", int'(x_pos), 0);
        check("rst_hsync", int'(hsync_n), 1);
        check("rst_vsync", int'(vsync_n), 1);
        check("rst_blank", int'(blank), 1);
        check("rst_fs", int'(frame_start), 0);
        repeat (3) tick();

        // Release: first edge starts a frame at the origin
        reset = 1'b1;
        tick();
        check("rel_fs", int'(frame_start), 1);
        check("rel_ls", int'(line_start), 1);
        check("rel_blank", int'(blank), 0);

        // Two full frames of strobe statistics
        n_ls = 0; n_fs = 0; n_hs = 0; n_vs = 0; n_bl = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            n_ls += int'(line_start);
            n_fs += int'(frame_start);
            n_hs += int'(!hsync_n);
            n_vs += int'(!vsync_n);
            n_bl += int'(blank);
            if (i == HT * VT) begin
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
                check("fc_second_frame", int'(frame_count), 2);
`else
                check("fc_tied_zero", int'(frame_count), 0);
`endif
            end
            tick();
        end
        check("line_starts", n_ls, 38);
        check("frame_starts", n_fs, 2);
        check("hsync_low_clks", n_hs, 228);
        check("vsync_low_clks", n_vs, 120);
        check("blank_clks", n_bl, 756);

        // Offset write mid-frame only takes effect at the next frame
        for (int g = 0; g < 1000 && my != 5; g++) tick();
        x_offset = 10'd5; y_offset = 10'd1023;
        tick();
        check("scroll_held", int'(scroll_x), int'(x_pos));
        for (int g = 0; g < 1000 && !(mx == 0 && my == 0); g++) tick();
        check("frame_origin_x", int'(x_pos), 0);
        check("scroll_x_new_frame", int'(scroll_x), 5);
        check("scroll_y_wrap", int'(scroll_y), 1023);
        for (int g = 0; g < 100 && mx != 10; g++) tick();
        check("scroll_x_at10", int'(scroll_x), 15);
        x_offset = 10'd1020;
        for (int g = 0; g < 1000 && !(mx == 0 && my == 0); g++) tick();
        for (int g = 0; g < 100 && mx != 10; g++) tick();
        check("pos_at10", int'(x_pos), 10);
        check("scroll_x_wrap", int'(scroll_x), 6);

        // Drop enable mid-frame, then re-enable
        for (int g = 0; g < 1000 && !(mx == 20 && my == 8); g++) tick();
        check("drop_at_x", int'(x_pos), 20);
        enable = 1'b0;
        tick();
        check("drop_x", int'(x_pos), 0);
        check("drop_y", int'(y_pos), 0);
        check("drop_blank", int'(blank), 1);
        check("drop_hsync", int'(hsync_n), 1);
        x_offset = 10'd7;
        repeat (4) tick();
        enable = 1'b1;
        tick();
        check("reen_fs", int'(frame_start), 1);
        check("reen_scroll", int'(scroll_x), 7);

        // Asynchronous reset between edges
        for (int g = 0; g < 100 && mx != 7; g++) tick();
        x_offset = 10'd1020;
        reset = 1'b0;
        #1;
        check("arst_x", int'(x_pos), 0);
        check("arst_blank", int'(blank), 1);
        check("arst_hsync", int'(hsync_n), 1);
        check("arst_ls", int'(line_start), 0);
        check("arst_scroll", int'(scroll_x), 0);
        check("arst_fc", int'(frame_count), 0);
        repeat (3) tick();
        x_offset = 10'd0;
        reset = 1'b1;
        tick();
        check("arel_fs", int'(frame_start), 1);
        repeat (5) tick();
        check("arel_scroll", int'(scroll_x), 5);
        repeat (50) tick();

        @(negedge clk); #1;
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/display_timing.md
Name: display_timing

Overview:
- Raster timing generator that sits directly downstream of the control register file.
- Consumes the output-enable bit of MAIN_CTRL and the X_OFFSET/Y_OFFSET register values.
- Produces the refresh coordinates read back through X_POS/Y_POS, scrolled coordinates for the pixel fetch stage, and VGA sync/blank strobes.
- Offsets are frame-latched so scrolling never tears mid-frame.

Parameters:
- COORD_WIDTH, 10, width of counters, offsets and coordinate outputs.
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch (clocks).
- H_SYNC, 96, horizontal sync width (clocks).
- H_BACK, 48, horizontal back porch (clocks).
- V_VISIBLE, 480, active lines per frame.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BACK, 33, vertical back porch (lines).

Ports:
- clk  input  1  pixel clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- enable  input  1  MAIN_CTRL bit 0 (enable output).
- x_offset  input  COORD_WIDTH  X_OFFSET register value.
- y_offset  input  COORD_WIDTH  Y_OFFSET register value.
- x_pos  output  COORD_WIDTH  current horizontal counter; feeds the X_POS register.
- y_pos  output  COORD_WIDTH  current vertical counter; feeds the Y_POS register.
- scroll_x  output  COORD_WIDTH  x_pos + latched x offset, mod 2^COORD_WIDTH.
- scroll_y  output  COORD_WIDTH  y_pos + latched y offset, mod 2^COORD_WIDTH.
- hsync_n  output  1  horizontal sync, active low.
- vsync_n  output  1  vertical sync, active low.
- blank  output  1  1 outside the visible area or when disabled.
- line_start  output  1  one-clock pulse at x_pos==0.
- frame_start  output  1  one-clock pulse at x_pos==0, y_pos==0.
- frame_count  output  16  frames started since reset (optional feature).

Behaviour:
- H_TOTAL = sum of H_* parameters (800); V_TOTAL = sum of V_* parameters (525). Both must fit in COORD_WIDTH.
- Reset (reset==0, asynchronous): all counters and latched offsets = 0; hsync_n=1, vsync_n=1, blank=1, line_start=0, frame_start=0, frame_count=0.
- Idle (enable==0):
  - Counters held at 0; hsync_n=vsync_n=1; blank=1; pulses 0.
  - Latched offsets load x_offset/y_offset every clock, so the first frame after enable uses current values.
- Counting (enable==1), each clock:
  - x_pos increments; at H_TOTAL-1 it wraps to 0 and y_pos increments.
  - y_pos wraps from V_TOTAL-1 to 0 on the same edge that x_pos wraps.
- enable rising: first enabled cycle shows x_pos=0, y_pos=0, line_start=1, frame_start=1.
- enable falling mid-frame: the next edge forces counters to 0 and outputs to idle values; no partial-frame completion.
- All of hsync_n, vsync_n, blank, line_start and frame_start are registered. Each is computed from next-state counter values so it is cycle-aligned with x_pos/y_pos (zero skew, no pipeline offset).
- hsync_n=0 iff H_VISIBLE+H_FRONT <= x_pos < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- vsync_n=0 iff V_VISIBLE+V_FRONT <= y_pos < V_VISIBLE+V_FRONT+V_SYNC (490..491), for all x in those lines.
- blank=1 iff x_pos >= H_VISIBLE, or y_pos >= V_VISIBLE, or enable==0.
- Offset latch:
  - While enabled, the latched offsets load only on the edge that wraps the counters to (0,0), i.e. the edge that asserts frame_start.
  - Register writes at any other time are invisible until the next frame.
- scroll_x/scroll_y are combinational from the registered counters and latched offsets; addition truncates to COORD_WIDTH bits (wrap, no saturation).
- Reset asserted mid-frame overrides everything immediately. After release, counting resumes from (0,0) on the first edge with enable==1.

Optional Feature:
- Macro: DISPLAY_TIMING_FRAME_COUNT_EN.
- Defined: frame_count increments by 1 (mod 2^16) on every frame_start edge, holds when disabled, and clears on reset.
- Undefined: frame_count is tied to 0 and no counter logic is built.

Test Plan:
- Assert reset=0 for 3 clocks, enable=1 -> x_pos=0, y_pos=0, hsync_n=1, vsync_n=1, blank=1, pulses 0; release -> first cycle frame_start=1 at (0,0).
- Run 2 lines enabled -> line_start every 800 clocks; hsync_n low exactly for x_pos 656..751 (96 clocks); blank rises at x_pos=640 and falls at x_pos=0.
- Run 2 full frames -> frame_start every 420000 clocks; vsync_n low for y_pos 490..491 (1600 clocks); with DISPLAY_TIMING_FRAME_COUNT_EN, frame_count=2 after the second frame_start.
- Set x_offset=5 at y_pos=100 -> scroll_x==x_pos until the next frame_start, then scroll_x=5 at x_pos=0. Set x_offset=1020 -> at x_pos=10, scroll_x=6 (wrap).
- Drop enable at x_pos=300, y_pos=200 -> next edge x_pos=0, y_pos=0, blank=1, syncs high. Re-enable -> frame_start=1 on the first enabled cycle.
- Assert reset=0 asynchronously mid-line (no clock edge) -> outputs go to reset values immediately; latched offsets=0 and scroll_x=x_pos after release.
